// File: rtl/led_sequencer.sv
// Command-driven pattern sequencer for eight active-low LEDs: a valid/ready port
// selects a display mode and step rate, and a prescaler advances the pattern.
module led_sequencer #(
  parameter int CLK_FREQ  = 24000000,
  parameter int BASE_FREQ = 8
) (
  input  logic       CLK_24MHZ,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_MODE,
  input  logic [1:0] CMD_RATE,
  output logic [7:0] LED,
  output logic       STEP,
  output logic       BUSY
);

  localparam int P0    = CLK_FREQ / BASE_FREQ;
  localparam int CNT_W = $clog2(P0 * 8);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [1:0]        rate_q, rate_d;
  logic [7:0]        pattern_q, pattern_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              step_q, step_d;

  logic              accept;
  logic [CNT_W-1:0]  period_m1;

  assign accept = CMD_VALID & ready_q;

  // Terminal count for the current rate: period is P0 << rate cycles.
  always_comb begin
    case (rate_q)
      2'd0:    period_m1 = CNT_W'(P0 - 1);
      2'd1:    period_m1 = CNT_W'(P0 * 2 - 1);
      2'd2:    period_m1 = CNT_W'(P0 * 4 - 1);
      default: period_m1 = CNT_W'(P0 * 8 - 1);
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mode_d    = mode_q;
    rate_d    = rate_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b1;
    step_d    = 1'b0;

    if (accept) begin
      // A command accepted on a terminal-count edge discards that step.
      mode_d  = mode_e'(CMD_MODE);
      rate_d  = CMD_RATE;
      cnt_d   = '0;
      ready_d = 1'b0;
      dir_d   = 1'b1;
      case (mode_e'(CMD_MODE))
        MODE_BLINK: pattern_d = 8'hFF;
        MODE_SCAN:  pattern_d = 8'h01;
        default:    pattern_d = 8'h00;
      endcase
    end else if (mode_q == MODE_OFF) begin
      cnt_d = '0;
    end else if (cnt_q == period_m1) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        MODE_BLINK: pattern_d = ~pattern_q;
        MODE_SCAN: begin
          if (dir_q) begin
            if (pattern_q == 8'h80) begin
              pattern_d = 8'h40;
              dir_d     = 1'b0;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q == 8'h01) begin
              pattern_d = 8'h02;
              dir_d     = 1'b1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        default: pattern_d = pattern_q + 8'd1;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_24MHZ or negedge RST_N) begin
    if (!RST_N) begin
      mode_q    <= MODE_OFF;
      rate_q    <= 2'd0;
      pattern_q <= 8'h00;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      step_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      rate_q    <= rate_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      step_q    <= step_d;
    end
  end

  assign CMD_READY = ready_q;
  assign STEP      = step_q;
  assign LED       = ~pattern_q;
  assign BUSY      = (mode_q != MODE_OFF);

endmodule
